cbfp_block_unloader: RTL and testbench

- Parallel-to-serial unloader on the output side of the CBFP normalisation stage.
- Accepts one block of REG_DEPTH complex samples in parallel, together with a per-block normalisation shift, through a valid/ready handshake.
- Emits the samples one per beat in original arrival order, each scaled by an arithmetic left shift with saturation, under downstream backpressure.

---
 rtl/cbfp_block_unloader.sv | 129 ++++++++++++
 tb/tb_cbfp_block_unloader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_block_unloader.sv
// Parallel-to-serial unloader for CBFP-normalised blocks. It serialises one
// block oldest sample first, applying a saturating block left shift to each.
module cbfp_block_unloader #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned REG_DEPTH   = 4,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  din_i [0:REG_DEPTH-1],
  input  logic signed [DATA_WIDTH-1:0]  din_q [0:REG_DEPTH-1],
  input  logic [SHIFT_WIDTH-1:0]        in_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_i,
  output logic signed [DATA_WIDTH-1:0]  out_q,
  output logic [$clog2(REG_DEPTH)-1:0]  out_idx,
  output logic                          out_last
);

  localparam int unsigned CntW  = $clog2(REG_DEPTH);
  // Wide enough that the largest shift can never lose bits before clamping.
  localparam int unsigned FullW = DATA_WIDTH + (1 << SHIFT_WIDTH) - 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(REG_DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]  hold_i_q [0:REG_DEPTH-1];
  logic signed [DATA_WIDTH-1:0]  hold_q_q [0:REG_DEPTH-1];
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic                          accept;
  logic                          last_beat;
  logic [CntW-1:0]               rd_idx;

  function automatic logic signed [DATA_WIDTH-1:0] sat_shl(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]       s
  );
    logic signed [FullW-1:0] wide;
    wide = {{(FullW - DATA_WIDTH){x[DATA_WIDTH-1]}}, x} <<< s;
    // In range only if every bit above the result sign matches it.
    if (wide[FullW-1:DATA_WIDTH-1] == {(FullW - DATA_WIDTH + 1){wide[FullW-1]}}) begin
      return wide[DATA_WIDTH-1:0];
    end else if (wide[FullW-1]) begin
      return {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  endfunction

  assign last_beat = (state_q == StSend) && (cnt_q == LastCnt);
  assign in_ready  = (state_q == StIdle) || (last_beat && out_ready);
  assign accept    = in_valid && in_ready;
  assign rd_idx    = LastCnt - cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSend;
          cnt_d   = '0;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d = accept ? StSend : StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      for (int k = 0; k < int'(REG_DEPTH); k++) begin
        hold_i_q[k] <= '0;
        hold_q_q[k] <= '0;
      end
    end else if (accept) begin
      shift_q <= in_shift;
      for (int k = 0; k < int'(REG_DEPTH); k++) begin
        hold_i_q[k] <= din_i[k];
        hold_q_q[k] <= din_q[k];
      end
    end
  end

  // Outputs are gated by state so an idle or reset unloader presents zeros.
  always_comb begin
    out_valid = 1'b0;
    out_i     = '0;
    out_q     = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (state_q == StSend) begin
      out_valid = 1'b1;
      out_i     = sat_shl(hold_i_q[rd_idx], shift_q);
      out_q     = sat_shl(hold_q_q[rd_idx], shift_q);
      out_idx   = cnt_q;
      out_last  = last_beat;
    end
  end

endmodule

// File: tb/tb_cbfp_block_unloader.sv
// Self-checking bench: directed scenarios plus random blocks, scored against a
// queue of expected beats built from plain-integer shift-and-clamp arithmetic.
module tb_cbfp_block_unloader;

  localparam int DW = 16;
  localparam int RD = 4;
  localparam int SW = 5;
  localparam int IW = $clog2(RD);

  typedef struct {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic [IW-1:0]        idx;
    logic                 last;
  } beat_t;

  logic                 clk;
  logic                 rstn;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] blk_i [0:RD-1];
  logic signed [DW-1:0] blk_q [0:RD-1];
  logic [SW-1:0]        blk_shift;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic [IW-1:0]        out_idx;
  logic                 out_last;

  int    errors;
  int    checks;
  bit    accepted;
  bit    rand_ready;
  beat_t exp_q[$];

  cbfp_block_unloader #(
    .DATA_WIDTH (DW),
    .REG_DEPTH  (RD),
    .SHIFT_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din_i    (blk_i),
    .din_q    (blk_q),
    .in_shift (blk_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_i    (out_i),
    .out_q    (out_q),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_ref(int x, int s);
    longint v;
    longint mx;
    v  = longint'(x) * (longint'(1) << s);
    mx = (longint'(1) << (DW - 1)) - 1;
    if (v > mx) v = mx;
    if (v < -mx - 1) v = -mx - 1;
    return int'(v);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_blk(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3,
                         input int sh);
    blk_i[0] = DW'(a0); blk_i[1] = DW'(a1); blk_i[2] = DW'(a2); blk_i[3] = DW'(a3);
    blk_q[0] = DW'(b0); blk_q[1] = DW'(b1); blk_q[2] = DW'(b2); blk_q[3] = DW'(b3);
    blk_shift = SW'(sh);
  endtask

  // One clock: score outputs at the falling edge, then advance past the rising edge.
  task automatic step();
    logic  exp_rdy;
    beat_t b;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("out_i", $signed(out_i), $signed(exp_q[0].i));
      chk("out_q", $signed(out_q), $signed(exp_q[0].q));
      chk("out_idx", {62'd0, out_idx}, {62'd0, exp_q[0].idx});
      chk("out_last", {63'd0, out_last}, {63'd0, exp_q[0].last});
      if (out_ready) void'(exp_q.pop_front());
    end
    if (in_valid && exp_rdy) begin
      for (int c = 0; c < RD; c++) begin
        b.i    = DW'(sat_ref(int'(blk_i[RD-1-c]), int'(blk_shift)));
        b.q    = DW'(sat_ref(int'(blk_q[RD-1-c]), int'(blk_shift)));
        b.idx  = IW'(c);
        b.last = (c == RD - 1);
        exp_q.push_back(b);
      end
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic offer();
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) step();
    chk("offer_accepted", {63'd0, accepted}, 64'sd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
    chk("drain_empty", exp_q.size(), 64'sd0);
    step();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    accepted   = 1'b0;
    rand_ready = 1'b0;
    rstn       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    set_blk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("rst_out_i", $signed(out_i), 64'sd0);
    chk("rst_out_q", $signed(out_q), 64'sd0);
    chk("rst_out_idx", {62'd0, out_idx}, 64'sd0);
    chk("rst_out_last", {63'd0, out_last}, 64'sd0);
    #10;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'sd1);

    // Single block, no shift.
    set_blk(4, 3, 2, 1, -4, -3, -2, -1, 0);
    offer();
    drain();

    // Scaling and saturation, then an oversized shift.
    set_blk(100, -100, 5000, -32768, -32768, 5000, -100, 100, 3);
    offer();
    drain();
    set_blk(0, 1, -1, 0, 0, -32768, 32767, 0, 20);
    offer();
    drain();

    // Backpressure while beat 1 is presented.
    set_blk(11, 22, 33, 44, -11, -22, -33, -44, 1);
    offer();
    step();
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) step();
    out_ready = 1'b1;
    drain();

    // Back-to-back blocks with different shifts.
    set_blk(1000, 2000, 3000, 4000, -1, -2, -3, -4, 1);
    offer();
    set_blk(7, 8, 9, 10, 5, 6, 7, 8, 2);
    offer();
    drain();

    // in_valid while mid-block must be ignored.
    set_blk(50, 60, 70, 80, 1, 2, 3, 4, 0);
    offer();
    set_blk(-9, -9, -9, -9, 9, 9, 9, 9, 7);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    drain();

    // Asynchronous reset after beat 1.
    set_blk(5, 6, 7, 8, -5, -6, -7, -8, 2);
    offer();
    step();
    step();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("arst_out_i", $signed(out_i), 64'sd0);
    chk("arst_out_q", $signed(out_q), 64'sd0);
    chk("arst_out_idx", {62'd0, out_idx}, 64'sd0);
    chk("arst_out_last", {63'd0, out_last}, 64'sd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    step();
    set_blk(-1, -2, -3, -4, 1, 2, 3, 4, 4);
    offer();
    drain();

    // Random blocks, gaps and backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < RD; k++) begin
        case ($urandom_range(0, 5))
          0:       blk_i[k] = 16'sh8000;
          1:       blk_i[k] = 16'sh7fff;
          default: blk_i[k] = DW'($urandom);
        endcase
        blk_q[k] = ($urandom_range(0, 5) == 0) ? 16'sh0000 : DW'($urandom_range(0, 511) - 256);
      end
      blk_shift = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(16, 31))
                                              : SW'($urandom_range(0, 6));
      offer();
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
